// File: rtl/float32_fixed_pkg.sv
// Shared float32 field definitions, input classification and stage records
// for the pipelined float32 -> fixed-point converter.
package float32_fixed_pkg;

    localparam int unsigned F32_W     = 32;
    localparam int unsigned F32_EXP_W = 8;
    localparam int unsigned F32_MAN_W = 23;
    localparam int unsigned F32_BIAS  = 127;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } f32_class_t;

    // S1 -> S2: unpacked input, mantissa carries the hidden bit
    typedef struct packed {
        logic                 sign;
        logic [F32_EXP_W-1:0] expo;
        logic [F32_MAN_W:0]   man;
        f32_class_t           cls;
    } s1_rec_t;

    // S2 -> S3: control part of the aligned word; the WOI+WOF magnitude
    // travels beside it because package structs cannot take parameters
    typedef struct packed {
        logic       sign;
        f32_class_t cls;
        logic       guard;
        logic       sticky;
        logic       ovf;
    } s2_rec_t;

    function automatic s1_rec_t unpack_f32(input logic [F32_W-1:0] f);
        s1_rec_t r;
        r.sign = f[F32_W-1];
        r.expo = f[F32_W-2 -: F32_EXP_W];
        r.man  = {(r.expo != '0), f[F32_MAN_W-1:0]};
        if (r.expo == '0)
            r.cls = ZERO;
        else if (r.expo == '1)
            r.cls = (f[F32_MAN_W-1:0] == '0) ? INF : NAN;
        else
            r.cls = NORM;
        return r;
    endfunction

endpackage

// File: rtl/float32_fixed_align.sv
// S2 combinational aligner: shifts the 24-bit mantissa to the WOI.WOF grid and
// reports guard, sticky and pre-rounding overflow against the signed range.
module float32_fixed_align
    import float32_fixed_pkg::*;
#(
    parameter int WOI = 10,
    parameter int WOF = 10
) (
    input  logic                 sign,
    input  logic [F32_EXP_W-1:0] expo,
    input  logic [F32_MAN_W:0]   man,
    output logic [WOI+WOF-1:0]   mag,
    output logic                 guard,
    output logic                 sticky,
    output logic                 ovf
);

    localparam int W  = WOI + WOF;
    localparam int MW = W + F32_MAN_W + 1;
    localparam logic signed [15:0] SH_OFS =
        16'(WOF - int'(F32_BIAS) - int'(F32_MAN_W));
    localparam logic [MW-1:0] LIM_POS = MW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic [MW-1:0] LIM_NEG = MW'(64'd1 << (W - 1));

    logic signed [15:0] sh;
    logic [7:0]         rsh;
    logic [71:0]        ext;
    logic [MW-1:0]      wide;

    always_comb begin
        sh     = $signed({8'd0, expo}) + SH_OFS;
        rsh    = '0;
        ext    = '0;
        wide   = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        ovf    = 1'b0;
        if (!sh[15]) begin
            // any left shift of W or more puts the hidden bit past the range
            if (sh >= 16'(W))
                ovf = 1'b1;
            else
                wide = MW'(man) << sh[7:0];
        end else begin
            // 48 spare bits below the mantissa; clamping at 71 keeps every
            // shifted-out bit inside the sticky window
            rsh    = (sh < -16'sd71) ? 8'd71 : 8'(-sh);
            ext    = {man, 48'd0} >> rsh;
            wide   = MW'(ext[71:48]);
            guard  = ext[47];
            sticky = |ext[46:0];
        end
        ovf = ovf | (wide > (sign ? LIM_NEG : LIM_POS));
        mag = wide[W-1:0];
    end

endmodule

// File: rtl/float32_to_fixed_stream.sv
// Three-stage valid/ready float32 -> signed WOI.WOF fixed-point converter.
// Optional statistics counters are built when FLOAT2FIXED_STATS_EN is defined.
module float32_to_fixed_stream
    import float32_fixed_pkg::*;
#(
    parameter int WOI   = 10,
    parameter int WOF   = 10,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [F32_W-1:0]   i_float,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [WOI+WOF-1:0] o_fixed,
    output logic               o_upflow,
    output logic               o_downflow,
    input  logic               stat_clr,
    output logic [15:0]        stat_up_cnt,
    output logic [15:0]        stat_dn_cnt
);

    localparam int W = WOI + WOF;
    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W:0]   LIM_POS = {1'b0, SAT_POS};
    localparam logic [W:0]   LIM_NEG = {1'b0, SAT_NEG};

    logic          v1_q, v2_q;
    logic          rdy2, rdy3;
    s1_rec_t       s1_d, s1_q;
    s2_rec_t       s2_q;
    logic [W-1:0]  mag2_q;
    logic [W-1:0]  mag_a;
    logic          guard_a, sticky_a, ovf_a;
    logic [W:0]    rnd;
    logic          ovf3;
    logic [W-1:0]  res_signed, res_d;
    logic          up_d, dn_d;

    assign rdy3    = ~o_valid | o_ready;
    assign rdy2    = ~v2_q | rdy3;
    assign i_ready = ~v1_q | rdy2;
    assign s1_d    = unpack_f32(i_float);

    float32_fixed_align #(
        .WOI (WOI),
        .WOF (WOF)
    ) u_align (
        .sign   (s1_q.sign),
        .expo   (s1_q.expo),
        .man    (s1_q.man),
        .mag    (mag_a),
        .guard  (guard_a),
        .sticky (sticky_a),
        .ovf    (ovf_a)
    );

    always_comb begin
        rnd = {1'b0, mag2_q};
        if (ROUND != 0)
            rnd = rnd + (W+1)'(s2_q.guard);
        ovf3       = s2_q.ovf | (rnd > (s2_q.sign ? LIM_NEG : LIM_POS));
        res_signed = s2_q.sign ? (~rnd[W-1:0] + 1'b1) : rnd[W-1:0];
        res_d      = '0;
        up_d       = 1'b0;
        dn_d       = 1'b0;
        case (s2_q.cls)
            ZERO: ;
            NORM: begin
                up_d  = ovf3;
                res_d = (ovf3 && ROOF != 0) ? (s2_q.sign ? SAT_NEG : SAT_POS)
                                            : res_signed;
                dn_d  = (res_d == '0) && ((|mag2_q) | s2_q.guard | s2_q.sticky);
            end
            INF: begin
                res_d = s2_q.sign ? SAT_NEG : SAT_POS;
                up_d  = 1'b1;
            end
            NAN: up_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            o_valid    <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            mag2_q     <= '0;
            o_fixed    <= '0;
            o_upflow   <= 1'b0;
            o_downflow <= 1'b0;
        end else begin
            if (i_ready) begin
                v1_q <= i_valid;
                if (i_valid)
                    s1_q <= s1_d;
            end
            if (rdy2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    s2_q   <= '{sign: s1_q.sign, cls: s1_q.cls, guard: guard_a,
                                sticky: sticky_a, ovf: ovf_a};
                    mag2_q <= mag_a;
                end
            end
            // output word only changes when empty or consumed, so it holds under backpressure
            if (rdy3) begin
                o_valid <= v2_q;
                if (v2_q) begin
                    o_fixed    <= res_d;
                    o_upflow   <= up_d;
                    o_downflow <= dn_d;
                end
            end
        end
    end

`ifdef FLOAT2FIXED_STATS_EN
    logic        out_fire;
    logic [15:0] up_cnt_q, dn_cnt_q;

    assign out_fire = o_valid & o_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            up_cnt_q <= '0;
            dn_cnt_q <= '0;
        end else if (stat_clr) begin
            up_cnt_q <= '0;
            dn_cnt_q <= '0;
        end else if (out_fire) begin
            if (o_upflow && up_cnt_q != '1)
                up_cnt_q <= up_cnt_q + 16'd1;
            if (o_downflow && dn_cnt_q != '1)
                dn_cnt_q <= dn_cnt_q + 16'd1;
        end
    end

    assign stat_up_cnt = up_cnt_q;
    assign stat_dn_cnt = dn_cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_up_cnt     = '0;
    assign stat_dn_cnt     = '0;
`endif

endmodule

// File: doc/float32_to_fixed_stream.md
# float32_to_fixed_stream

Pipelined, flow-controlled IEEE-754 single-precision to signed fixed-point converter. Functionally it matches the team's combinational float-to-fixed converter, but it splits the datapath into three registered stages with valid/ready handshaking. It sits between a float32 producer (AXI-stream-like source, FIFO) and fixed-point consumers in the DSP chain, replacing the combinational converter where timing closure at full clock rate is required.

## Interface
Parameters:
- WOI, 10, integer bits of output, including sign.
- WOF, 10, fractional bits of output.
- ROOF, 1, 1 = saturate on overflow; 0 = wrap (keep low WOI+WOF bits).
- ROUND, 1, 1 = round half away from zero; 0 = truncate toward zero.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rstn, in, 1, asynchronous active-low reset.
- i_valid, in, 1, input word valid.
- i_ready, out, 1, block can accept input this cycle.
- i_float, in, 32, float32 input.
- o_valid, out, 1, output word valid.
- o_ready, in, 1, downstream accepts output.
- o_fixed, out, WOI+WOF, signed fixed-point result.
- o_upflow, out, 1, result overflowed, or input was Inf/NaN.
- o_downflow, out, 1, nonzero input produced a zero result.
- stat_clr, in, 1, synchronous clear of statistics counters.
- stat_up_cnt, out, 16, saturating count of accepted outputs with o_upflow.
- stat_dn_cnt, out, 16, saturating count of accepted outputs with o_downflow.

## Operation
- Stage S1 (unpack):
  - Register sign, 8-bit exponent and 24-bit mantissa (hidden bit set when exp≠0).
  - Classify the input as ZERO (exp=0, includes denormals), NORM, INF, or NAN.
- Stage S2 (align):
  - Shift the mantissa by exp−127−23+WOF. Left shift if positive, right shift otherwise.
  - Keep a guard bit and a sticky OR of the shifted-out bits.
  - Detect overflow when the magnitude exceeds 2^(WOI+WOF−1)−1 for positive inputs, or 2^(WOI+WOF−1) for negative inputs.
- Stage S3 (round/saturate/sign):
  - ROUND=1: add the guard bit to the magnitude. Ties round away from zero; the sticky bit only affects downflow.
  - After rounding, re-check overflow, then negate if sign=1.
  - ROOF=1 saturates overflow to 0x7FFF.. for positive or 0x800.. for negative.
- Special cases:
  - INF saturates by sign, upflow=1.
  - NAN gives output 0, upflow=1.
  - ZERO gives output 0 with no flags; ±0 are identical.
  - Any NORM input whose final result is 0 gives downflow=1.
- Flags travel with their data word.

## Timing
- Latency: 3 cycles from input acceptance (i_valid&i_ready) to o_valid, when not backpressured. Throughput is 1 word per cycle.
- Each stage has its own valid bit and advances when the next stage is empty or advancing. i_ready = ~v1 | adv1; the last stage advances on o_ready.
- No combinational path from i_valid to i_ready. A combinational path o_ready→i_ready is allowed.
- Once o_valid=1, o_fixed and both flags hold stable until o_ready=1.
- Reset values: all stage valid bits 0, o_valid=0, o_fixed=0, o_upflow=0, o_downflow=0, counters 0. i_ready=1 from the first cycle after rstn deasserts.
- When rstn asserts mid-stream, in-flight words are discarded with no partial outputs.
- Counters increment only on output handshake. They saturate at 0xFFFF.
- When stat_clr and an increment occur in the same cycle, clear wins and the counter reads 0.

## Configuration
- FLOAT2FIXED_STATS_EN defined: the counters are implemented as described.
- FLOAT2FIXED_STATS_EN not defined:
  - The counters are not built.
  - stat_up_cnt and stat_dn_cnt are tied to 0 and stat_clr is ignored.
  - Datapath behaviour is unchanged.

## Structure
- Package float32_fixed_pkg holds:
  - Float32 field widths, bias 127, mantissa width 23.
  - Class enum {ZERO, NORM, INF, NAN}.
  - The S1→S2 and S2→S3 stage record structs.
- One sub-module, float32_fixed_align: the S2 combinational shifter with guard/sticky/overflow outputs, parameterised by WOI/WOF.
- The stage registers and handshake logic stay in the top module.

## Test plan
Defaults: WOI=10, WOF=10, ROOF=1, ROUND=1; o_ready=1 unless stated.
- Basic conversion:
  - 0xC36F0D77 (−239.0526) → o_fixed=−244790 (0xC43CA), no flags.
  - 0x407E7564 (3.9759) → 0x00FE7.
  - Each result appears exactly 3 cycles after acceptance.
- Overflow and specials:
  - 0x44696E31 (933.72) → 0x7FFFF, upflow=1.
  - 0xC46B581A (−941.38) → 0x80000, upflow=1.
  - 0x7F800000 → 0x7FFFF, upflow=1.
  - 0x7FC00000 → 0, upflow=1.
- Zeros and underflow:
  - 0x00000000 and 0x80000000 → 0, no flags.
  - 0x39800000 (2^−12) → 0, downflow=1.
  - 0x3A000000 (2^−11, tie) → 1, no flags.
- Backpressure:
  - Stream 100 random words; toggle o_ready pseudo-randomly at about 50%.
  - Output sequence must equal the golden model in order, with no drops or duplicates.
  - o_fixed must stay stable while o_valid&~o_ready.
- Reset mid-stream:
  - Assert rstn low with all 3 stages full.
  - o_valid must drop immediately.
  - After release, the first output is the first word accepted after reset.
- Statistics (with FLOAT2FIXED_STATS_EN):
  - Send 5 overflowing and 2 underflowing words → stat_up_cnt=5, stat_dn_cnt=2.
  - Pulse stat_clr in the same cycle as an upflow handshake → counter reads 0.
